// File: rtl/dispatch_pkg.sv
// Shared types and constants for the VLIW bundle dispatch front end.
package dispatch_pkg;

    localparam int SLOT_WIDTH = 32;

    typedef enum logic [1:0] {
        FETCH,
        ISSUE,
        WAIT_ACK,
        WAIT_DONE
    } state_t;

    function automatic logic [63:0] bundleBytes(input int num_slots);
        return 64'(num_slots) * 64'd4;
    endfunction

endpackage

// File: rtl/bundle_dispatch.sv
// Fetches one VLIW bundle, issues every slot to its functional unit, then waits for all units to finish.
// Optional feature: define REDIRECT_EN to add redirectValid/redirectAddr control-flow redirection.
module bundle_dispatch
    import dispatch_pkg::*;
#(
    parameter int          NUM_SLOTS = 4,
    parameter logic [63:0] RESET_PC  = 64'h0
) (
    input  logic                            clk,
    input  logic                            rst,
`ifdef REDIRECT_EN
    input  logic                            redirectValid,
    input  logic [63:0]                     redirectAddr,
`endif
    output logic                            imemReq,
    output logic [63:0]                     imemAddr,
    input  logic [SLOT_WIDTH*NUM_SLOTS-1:0] imemData,
    input  logic                            imemValid,
    output logic [SLOT_WIDTH*NUM_SLOTS-1:0] slotInstruction,
    output logic [63:0]                     bundleAddr,
    output logic [NUM_SLOTS-1:0]            instructionReady,
    input  logic [NUM_SLOTS-1:0]            fuWorking,
    output logic                            dispatchIdle
);

    state_t      state;
    state_t      state_next;
    logic [63:0] pc;
    logic [63:0] next_pc;
    logic        capture;
    logic        advance;

    assign capture = (state == FETCH) && imemReq && imemValid;
    assign advance = (state == WAIT_DONE) && !(|fuWorking);

`ifdef REDIRECT_EN
    logic        redir_pending;
    logic [63:0] redir_target;
    logic        redir_hit;

    // A redirect arriving in the exit cycle itself is the newest one, so it wins.
    assign redir_hit = redirectValid && (state != FETCH);
    assign next_pc   = redir_hit     ? redirectAddr :
                       redir_pending ? redir_target :
                                       pc + bundleBytes(NUM_SLOTS);

    always_ff @(posedge clk) begin
        if (rst) begin
            redir_pending <= 1'b0;
            redir_target  <= 64'h0;
        end else if (advance) begin
            redir_pending <= 1'b0;
        end else if (redir_hit) begin
            redir_pending <= 1'b1;
            redir_target  <= redirectAddr;
        end
    end
`else
    assign next_pc = pc + bundleBytes(NUM_SLOTS);
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= FETCH;
        else     state <= state_next;
    end

    always_comb begin
        // NOTE: default assignment first so every path drives state_next and no latch is inferred.
        state_next = state;
        unique case (state)
            FETCH:     if (capture)    state_next = ISSUE;
            ISSUE:                     state_next = WAIT_ACK;
            WAIT_ACK:  if (&fuWorking) state_next = WAIT_DONE;
            WAIT_DONE: if (advance)    state_next = FETCH;
            default:                   state_next = FETCH;
        endcase
    end

    always_comb begin
        instructionReady = '0;
        if (state == ISSUE) instructionReady = '1;
        dispatchIdle = (state == FETCH) && !imemReq;
    end

    // The request is raised straight from the WAIT_DONE exit so back-to-back bundles skip an idle cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc              <= RESET_PC;
            imemReq         <= 1'b0;
            imemAddr        <= RESET_PC;
            slotInstruction <= '0;
            bundleAddr      <= 64'h0;
        end else begin
            // NOTE: non-blocking updates so every register sees pre-edge values, independent of statement order.
            if (state == FETCH) begin
                if (capture) begin
                    slotInstruction <= imemData;
                    bundleAddr      <= pc;
                    imemReq         <= 1'b0;
                end else begin
                    imemReq  <= 1'b1;
                    imemAddr <= pc;
                end
            end
            if (advance) begin
                pc       <= next_pc;
                imemReq  <= 1'b1;
                imemAddr <= next_pc;
            end
        end
    end

endmodule

// File: tb/tb_bundle_dispatch.sv
// Self-checking bench for bundle_dispatch: memory and FU models, scoreboard of issued bundles.
// Two instances: one at RESET_PC 0x1000 for the main flow, one near 2^64 for address wrap.
module tb_bundle_dispatch;
    import dispatch_pkg::*;

    localparam int          NS   = 4;
    localparam int          BW   = SLOT_WIDTH * NS;
    localparam logic [63:0] PC_A = 64'h1000;
    localparam logic [63:0] PC_B = 64'hFFFF_FFFF_FFFF_FFF0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [BW-1:0] bundle_for(input logic [63:0] addr);
        logic [BW-1:0] b;
        b = '0;
        if (addr == 64'h1000) b = {32'hD, 32'hC, 32'hB, 32'hA};
        else for (int i = 0; i < NS; i++) b[i*32 +: 32] = {addr[23:0], 8'(i)};
        return b;
    endfunction

    // ---------------- instance A ----------------
    logic          rst_a;
    logic          imemReq_a, imemValid_a, dispatchIdle_a;
    logic [63:0]   imemAddr_a, bundleAddr_a;
    logic [BW-1:0] imemData_a, slotInstruction_a;
    logic [NS-1:0] instructionReady_a, fuWorking_a;
`ifdef REDIRECT_EN
    logic          redirectValid_a = 1'b0;
    logic [63:0]   redirectAddr_a  = 64'h0;
`endif

    bundle_dispatch #(.NUM_SLOTS(NS), .RESET_PC(PC_A)) dut_a (
        .clk(clk), .rst(rst_a),
`ifdef REDIRECT_EN
        .redirectValid(redirectValid_a), .redirectAddr(redirectAddr_a),
`endif
        .imemReq(imemReq_a), .imemAddr(imemAddr_a), .imemData(imemData_a), .imemValid(imemValid_a),
        .slotInstruction(slotInstruction_a), .bundleAddr(bundleAddr_a),
        .instructionReady(instructionReady_a), .fuWorking(fuWorking_a), .dispatchIdle(dispatchIdle_a)
    );

    // FU model: working rises the cycle after ready is sampled and lasts the unit's latency.
    int fu_cnt_a [NS];
    initial for (int i = 0; i < NS; i++) fu_cnt_a[i] = 0;
    always @(posedge clk)
        for (int i = 0; i < NS; i++) begin
            if (instructionReady_a[i]) fu_cnt_a[i] <= (i == 1) ? 6 : 2;
            else if (fu_cnt_a[i] > 0)  fu_cnt_a[i] <= fu_cnt_a[i] - 1;
        end
    always_comb for (int i = 0; i < NS; i++) fuWorking_a[i] = (fu_cnt_a[i] != 0);

    // Memory model: answers after mem_delay wait cycles with a one-cycle valid pulse, drops on reset.
    int mem_delay = 3;
    int mem_cnt   = 0;
    initial begin
        imemValid_a = 1'b0;
        imemData_a  = '0;
    end
    always @(negedge clk) begin
        if (rst_a) begin
            imemValid_a = 1'b0;
            mem_cnt     = 0;
        end else if (imemValid_a) begin
            imemValid_a = 1'b0;
        end else if (imemReq_a) begin
            if (mem_cnt >= mem_delay) begin
                imemValid_a = 1'b1;
                imemData_a  = bundle_for(imemAddr_a);
                mem_cnt     = 0;
            end else begin
                mem_cnt++;
            end
        end
    end

    // Scoreboard: expected {address, bundle} pushed on delivery, popped on the issue pulse.
    logic [63:0]       model_pc = PC_A;
    logic [64+BW-1:0]  sb_q [$];
    logic [NS-1:0]     prev_ready = '0;

    always @(posedge clk) begin
        if (rst_a) sb_q.delete();
        else if (imemReq_a && imemValid_a) sb_q.push_back({model_pc, imemData_a});
    end

    always @(negedge clk) begin
        if (!rst_a && instructionReady_a != '0) begin
            logic [64+BW-1:0] e;
            check("ready_all", 256'(instructionReady_a), 256'({NS{1'b1}}));
            check("ready_single", 256'(prev_ready), 256'(0));
            check("sb_depth", 256'(sb_q.size()), 256'(1));
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("sb_slots", 256'(slotInstruction_a), 256'(e[BW-1:0]));
                check("sb_addr", 256'(bundleAddr_a), 256'(e[64+BW-1:BW]));
            end
        end
        prev_ready = instructionReady_a;
    end

    task automatic wait_ready_a(input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (instructionReady_a == '0 && n < 100);
        check(tag, 256'(instructionReady_a), 256'({NS{1'b1}}));
    endtask

    task automatic wait_req_a(input string tag, output int cycles);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!imemReq_a && n < 100);
        check(tag, 256'(imemReq_a), 256'(1));
        cycles = n;
    endtask

    // ---------------- instance B (wrap) ----------------
    logic          rst_b;
    logic          imemReq_b, imemValid_b, dispatchIdle_b;
    logic [63:0]   imemAddr_b, bundleAddr_b;
    logic [BW-1:0] imemData_b, slotInstruction_b;
    logic [NS-1:0] instructionReady_b, fuWorking_b;
`ifdef REDIRECT_EN
    logic          redirectValid_b = 1'b0;
    logic [63:0]   redirectAddr_b  = 64'h0;
`endif

    bundle_dispatch #(.NUM_SLOTS(NS), .RESET_PC(PC_B)) dut_b (
        .clk(clk), .rst(rst_b),
`ifdef REDIRECT_EN
        .redirectValid(redirectValid_b), .redirectAddr(redirectAddr_b),
`endif
        .imemReq(imemReq_b), .imemAddr(imemAddr_b), .imemData(imemData_b), .imemValid(imemValid_b),
        .slotInstruction(slotInstruction_b), .bundleAddr(bundleAddr_b),
        .instructionReady(instructionReady_b), .fuWorking(fuWorking_b), .dispatchIdle(dispatchIdle_b)
    );

    int fu_cnt_b [NS];
    initial for (int i = 0; i < NS; i++) fu_cnt_b[i] = 0;
    always @(posedge clk)
        for (int i = 0; i < NS; i++) begin
            if (instructionReady_b[i]) fu_cnt_b[i] <= 2;
            else if (fu_cnt_b[i] > 0)  fu_cnt_b[i] <= fu_cnt_b[i] - 1;
        end
    always_comb for (int i = 0; i < NS; i++) fuWorking_b[i] = (fu_cnt_b[i] != 0);

    // Zero-wait memory: valid in the first request cycle.
    initial begin
        imemValid_b = 1'b0;
        imemData_b  = '0;
    end
    always @(negedge clk) begin
        imemValid_b = imemReq_b && !rst_b && !imemValid_b;
        imemData_b  = bundle_for(imemAddr_b);
    end

    // ---------------- stimulus ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_a = 1'b1;
        rst_b = 1'b1;
        fork
            begin : thread_a
                int n;
                logic [63:0] exp_next;
                repeat (3) @(negedge clk);
                check("rst_req", 256'(imemReq_a), 256'(0));
                check("rst_addr", 256'(imemAddr_a), 256'(PC_A));
                check("rst_slots", 256'(slotInstruction_a), 256'(0));
                check("rst_baddr", 256'(bundleAddr_a), 256'(0));
                check("rst_ready", 256'(instructionReady_a), 256'(0));
                check("rst_idle", 256'(dispatchIdle_a), 256'(1));
                rst_a = 1'b0;
                @(negedge clk);
                check("first_req", 256'(imemReq_a), 256'(1));
                check("first_addr", 256'(imemAddr_a), 256'(PC_A));
                check("first_ready", 256'(instructionReady_a), 256'(0));
                check("first_idle", 256'(dispatchIdle_a), 256'(0));

                wait_ready_a("ready_b0");
                check("b0_slot0", 256'(slotInstruction_a[31:0]), 256'(32'hA));
                check("b0_slot3", 256'(slotInstruction_a[127:96]), 256'(32'hD));
                check("b0_baddr", 256'(bundleAddr_a), 256'(64'h1000));
                model_pc  = 64'h1010;
                mem_delay = 1;

                // FU1 busy 6 cycles: the next request must wait for it.
                wait_req_a("req_b1", n);
                check("req_latency", 256'(n), 256'(8));
                check("req_fu_idle", 256'(fuWorking_a), 256'(0));
                check("b1_addr", 256'(imemAddr_a), 256'(64'h1010));
                wait_ready_a("ready_b1");

                // Reset while in WAIT_DONE with FU1 still working.
                model_pc  = PC_A;
                mem_delay = 6;
                repeat (2) @(negedge clk);
                rst_a = 1'b1;
                @(negedge clk);
                check("mid_rst_addr", 256'(imemAddr_a), 256'(PC_A));
                check("mid_rst_slots", 256'(slotInstruction_a), 256'(0));
                check("mid_rst_baddr", 256'(bundleAddr_a), 256'(0));
                check("mid_rst_idle", 256'(dispatchIdle_a), 256'(1));
                rst_a = 1'b0;
                for (int i = 0; i < 4; i++) begin
                    @(negedge clk);
                    check("late_fu_no_issue", 256'(instructionReady_a), 256'(0));
                end
                wait_ready_a("ready_b2");
                check("b2_slot0", 256'(slotInstruction_a[31:0]), 256'(32'hA));

`ifdef REDIRECT_EN
                @(negedge clk);
                redirectValid_a = 1'b1;
                redirectAddr_a  = 64'h2000;
                @(negedge clk);
                redirectAddr_a  = 64'h3000;
                @(negedge clk);
                redirectValid_a = 1'b0;
                exp_next = 64'h3000;
`else
                exp_next = 64'h1010;
`endif
                model_pc  = exp_next;
                mem_delay = 1;
                wait_req_a("req_b3", n);
                check("b3_addr", 256'(imemAddr_a), 256'(exp_next));
                wait_ready_a("ready_b3");
                model_pc = exp_next + 64'd16;
                wait_req_a("req_b4", n);
                check("b4_addr", 256'(imemAddr_a), 256'(exp_next + 64'd16));
                wait_ready_a("ready_b4");
                @(negedge clk);
                check("sb_drained", 256'(sb_q.size()), 256'(0));
            end
            begin : thread_b
                int n;
                repeat (3) @(negedge clk);
                rst_b = 1'b0;
                @(negedge clk);
                check("wrap_first_req", 256'(imemReq_b), 256'(1));
                check("wrap_first_addr", 256'(imemAddr_b), 256'(PC_B));
                n = 0;
                do begin @(negedge clk); n++; end while (instructionReady_b == '0 && n < 50);
                check("wrap_ready0", 256'(instructionReady_b), 256'({NS{1'b1}}));
                check("wrap_baddr0", 256'(bundleAddr_b), 256'(PC_B));
                check("wrap_slots0", 256'(slotInstruction_b), 256'(bundle_for(PC_B)));
                n = 0;
                do begin @(negedge clk); n++; end while (!imemReq_b && n < 50);
                check("wrap_req1", 256'(imemReq_b), 256'(1));
                check("wrap_addr1", 256'(imemAddr_b), 256'(0));
                n = 0;
                do begin @(negedge clk); n++; end while (instructionReady_b == '0 && n < 50);
                check("wrap_ready1", 256'(instructionReady_b), 256'({NS{1'b1}}));
                check("wrap_baddr1", 256'(bundleAddr_b), 256'(0));
            end
        join
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
